// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: bus command codes, FSM states,
// read-data source selection and the default I/O addresses.
package mem_responder_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [1:0] MILL   = 2'b11;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Which value read_data presents while mem_ready is high.
  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_SW   = 2'd2,
    SRC_ZERO = 2'd3
  } src_t;

  function automatic logic req_is_err(input logic [1:0] cmd, input logic hit_ram,
                                      input logic hit_led, input logic hit_sw);
    logic bad;
    bad = (cmd == MILL) || !(hit_ram || hit_led || hit_sw);
    bad = bad || ((cmd == MREAD) && hit_led) || ((cmd == MWRITE) && hit_sw);
    return bad;
  endfunction

endpackage

// File: rtl/mem_ram_sp.sv
// Single-port synchronous RAM with a registered read port.
module mem_ram_sp #(
  parameter int WORDS  = 256,
  parameter int DATA_W = 16,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: decodes RAM / LED / switch accesses, inserts read
// wait states and signals completion with a one-cycle mem_ready pulse.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int              ADDR_W      = 9,
  parameter int              DATA_W      = 16,
  parameter int              RAM_WORDS   = 256,
  parameter int              WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR  = LED_ADDR_DEF,
  parameter logic [ADDR_W-1:0] SW_ADDR   = SW_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              bus_err,
  input  logic [7:0]        sw,
  output logic [7:0]        led,
  output logic [1:0]        fsm_state
);

  localparam int IDX_W = $clog2(RAM_WORDS);
  localparam logic [ADDR_W:0]   RAM_LIMIT = (ADDR_W+1)'(RAM_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_t            state, state_nxt;
  src_t              src_q, src_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              err_q, err_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        sw_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] ram_dout;
  logic [IDX_W-1:0]  ram_idx;
  logic              ram_we, ram_re, led_we;
  logic              hit_ram, hit_led, hit_sw, req_err, accept, enter_done;

  always_comb begin
    hit_ram = ({1'b0, mem_addr} < RAM_LIMIT);
    hit_led = (mem_addr == LED_ADDR);
    hit_sw  = (mem_addr == SW_ADDR);
    req_err = req_is_err(mem_cmd, hit_ram, hit_led, hit_sw);
    accept  = (state == IDLE) && (mem_cmd != MNONE);
  end

  // Writes commit on the accept edge; only reads ever visit RD_WAIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    src_nxt   = src_q;
    err_nxt   = err_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    led_we    = 1'b0;
    ram_idx   = idx_q;
    case (state)
      IDLE: begin
        ram_idx = mem_addr[IDX_W-1:0];
        if (accept) begin
          err_nxt   = req_err;
          state_nxt = DONE;
          if (req_err) begin
            src_nxt = SRC_ZERO;
          end else if (mem_cmd == MWRITE) begin
            src_nxt = SRC_HOLD;
            ram_we  = hit_ram;
            led_we  = hit_led;
          end else begin
            src_nxt = hit_ram ? SRC_RAM : SRC_SW;
            if (WAIT_STATES == 0) begin
              ram_re = hit_ram;
            end else begin
              state_nxt = RD_WAIT;
              cnt_nxt   = CNT_LOAD;
            end
          end
        end
      end
      RD_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = DONE;
          ram_re    = (src_q == SRC_RAM);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_done = (state_nxt == DONE) && (state != DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      src_q  <= SRC_HOLD;
      cnt    <= '0;
      err_q  <= 1'b0;
      idx_q  <= '0;
      sw_q   <= '0;
      hold_q <= '0;
      led    <= '0;
    end else begin
      state <= state_nxt;
      src_q <= src_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
      if (accept)     idx_q  <= mem_addr[IDX_W-1:0];
      if (enter_done) sw_q   <= sw;
      if (led_we)     led    <= write_data[7:0];
      if (state == DONE) hold_q <= read_data;
    end
  end

  // Between completions read_data replays whatever was last presented.
  always_comb begin
    mem_ready = (state == DONE);
    bus_err   = mem_ready && err_q;
    read_data = hold_q;
    if (state == DONE) begin
      case (src_q)
        SRC_RAM:  read_data = ram_dout;
        SRC_SW:   read_data = {{(DATA_W-8){1'b0}}, sw_q};
        SRC_ZERO: read_data = '0;
        default:  read_data = hold_q;
      endcase
    end
  end

  assign fsm_state = state;

  mem_ram_sp #(
    .WORDS  (RAM_WORDS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_idx),
    .din  (write_data),
    .dout (ram_dout)
  );

endmodule
